// File: rtl/instr_pkg.sv
// Shared ISA field widths, format codes and writer FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package instr_pkg;

  localparam int INSTR_W   = 9;
  localparam int OPCODE_W  = 4;
  localparam int OPERAND_W = 3;
  localparam int IMM_W     = 8;

  localparam logic FMT_IMM = 1'b1;
  localparam logic FMT_REG = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into one 9-bit ISA word.
// Latency: combinational, zero cycles.
// Backpressure: none; fields not used by the selected format are ignored.
module instr_encoder
  import instr_pkg::*;
(
  input  logic                 format,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 sign,
  input  logic [OPERAND_W-1:0] operand,
  input  logic [IMM_W-1:0]     immediate,
  output logic [INSTR_W-1:0]   word
);

  // Immediate format carries the whole payload; register format packs opcode/sign/operand.
  assign word = (format == FMT_IMM) ? {FMT_IMM, immediate}
                                    : {FMT_REG, opcode, sign, operand};

endmodule

// File: rtl/instr_mem_writer.sv
// Packs field tuples and writes them to sequential RAM slots; fetch reads them back by pc_in.
// Latency: write lands on the accepting edge; instr_out is registered, 1 cycle after pc_in.
// Backpressure: wr_ready only in LOAD; start overrides a same-cycle tuple. INSTR_CHECKSUM_EN adds checksum.
module instr_mem_writer
  import instr_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 format,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 sign,
  input  logic [OPERAND_W-1:0] operand,
  input  logic [IMM_W-1:0]     immediate,
  output logic [ADDR_W:0]      wr_count,
  output logic                 done,
  input  logic [15:0]          pc_in,
  output logic [INSTR_W-1:0]   instr_out
`ifdef INSTR_CHECKSUM_EN
  ,
  output logic [INSTR_W-1:0]   checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = DEPTH[ADDR_W:0];

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic [ADDR_W-1:0]   ptr_q;
  logic [INSTR_W-1:0]  wr_word;
  logic [INSTR_W-1:0]  mem [DEPTH];

  instr_encoder u_encoder (
    .format    (format),
    .opcode    (opcode),
    .sign      (sign),
    .operand   (operand),
    .immediate (immediate),
    .word      (wr_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; start wins over everything, including a pending tuple.
  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: ;
      LOAD: begin
        wr_ready = 1'b1;
        accept   = wr_valid && !start;
        if (accept && ptr_q == LAST_ADDR) state_d = FULL;
      end
      FULL: done = 1'b1;
      default: state_d = IDLE;
    endcase
    if (start) state_d = LOAD;
  end

  // Write pointer and word counter; count saturates at DEPTH, pointer wraps harmlessly in FULL.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      ptr_q    <= '0;
      wr_count <= '0;
    end else if (accept) begin
      ptr_q <= ptr_q + 1'b1;
      if (wr_count != FULL_COUNT) wr_count <= wr_count + 1'b1;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) mem[ptr_q] <= wr_word;
  end

  // Registered read; same-address write in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (reset)                    instr_out <= '0;
    else if (pc_in < 16'(DEPTH))  instr_out <= mem[pc_in[ADDR_W-1:0]];
    else                          instr_out <= '0;
  end

`ifdef INSTR_CHECKSUM_EN
  // Running XOR of every accepted word, restarted by reset or start.
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (accept)    checksum <= checksum ^ wr_word;
  end
`endif

endmodule
